// File: rtl/trace_monitor.sv
// Trace monitor: records issued instructions and matches each unit retirement back to them, emitting one record per cycle.
// Latency: record one edge after capture. No backpressure; a pending-slot overwrite raises overflow_err. TRACEMON_HALT_CHECK_EN adds halt_err.
module trace_monitor #(
  parameter int DEPTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wave2decode_instr_valid,
  input  logic [31:0]   wave2decode_instr,
  input  logic [31:0]   wave2decode_instr_pc,
  input  logic [8:0]    wave2decode_sgpr_base,
  input  logic [9:0]    wave2decode_vgpr_base,
  input  logic [9:0]    wave2decode_lds_base,
  input  logic [5:0]    wave2decode_wfid,
  input  logic          salu2exec_wr_exec_en,
  input  logic [63:0]   salu2exec_wr_exec_value,
  input  logic          salu2exec_wr_vcc_en,
  input  logic [63:0]   salu2exec_wr_vcc_value,
  input  logic          salu_wr_scc_en,
  input  logic          salu_wr_scc_value,
  input  logic          salu2sgpr_dest_wr_en,
  input  logic [8:0]    salu2sgpr_dest_addr,
  input  logic [31:0]   salu2sgpr_dest_data,
  input  logic          simd12exec_wr_vcc_en,
  input  logic [63:0]   simd12exec_wr_vcc_value,
  input  logic          simd12vgpr_dest_wr_en,
  input  logic [9:0]    simd12vgpr_dest_addr,
  input  logic [2047:0] simd12vgpr_dest_data,
  input  logic [63:0]   simd12vgpr_wr_mask,
  input  logic          simd22exec_wr_vcc_en,
  input  logic [63:0]   simd22exec_wr_vcc_value,
  input  logic          simd22vgpr_dest_wr_en,
  input  logic [9:0]    simd22vgpr_dest_addr,
  input  logic [2047:0] simd22vgpr_dest_data,
  input  logic [63:0]   simd22vgpr_wr_mask,
  input  logic          simd32exec_wr_vcc_en,
  input  logic [63:0]   simd32exec_wr_vcc_value,
  input  logic          simd32vgpr_dest_wr_en,
  input  logic [9:0]    simd32vgpr_dest_addr,
  input  logic [2047:0] simd32vgpr_dest_data,
  input  logic [63:0]   simd32vgpr_wr_mask,
  input  logic          simd42exec_wr_vcc_en,
  input  logic [63:0]   simd42exec_wr_vcc_value,
  input  logic          simd42vgpr_dest_wr_en,
  input  logic [9:0]    simd42vgpr_dest_addr,
  input  logic [2047:0] simd42vgpr_dest_data,
  input  logic [63:0]   simd42vgpr_wr_mask,
  input  logic          lsu2sgpr_dest_wr_en,
  input  logic [8:0]    lsu2sgpr_dest_addr,
  input  logic [31:0]   lsu2sgpr_dest_data,
  input  logic          lsu2vgpr_dest_wr_en,
  input  logic [2047:0] lsu2vgpr_dest_data,
  input  logic [9:0]    lsu_dest_str_addr,
  input  logic [63:0]   lsu_dest_str_mask,
  input  logic [2047:0] lsu_addr,
  input  logic [2047:0] lsu_store_data,
  input  logic          issue_halt,
  input  logic [5:0]    issue_halt_wfid,
  input  logic          salu_retire_valid,
  input  logic [31:0]   salu_retire_pc,
  input  logic [5:0]    salu_wfid,
  input  logic          simd1_retire_valid,
  input  logic [31:0]   simd1_retire_pc,
  input  logic [5:0]    simd1_wfid,
  input  logic          simd2_retire_valid,
  input  logic [31:0]   simd2_retire_pc,
  input  logic [5:0]    simd2_wfid,
  input  logic          simd3_retire_valid,
  input  logic [31:0]   simd3_retire_pc,
  input  logic [5:0]    simd3_wfid,
  input  logic          simd4_retire_valid,
  input  logic [31:0]   simd4_retire_pc,
  input  logic [5:0]    simd4_wfid,
  input  logic          lsu_retire_valid,
  input  logic [31:0]   lsu_retire_pc,
  input  logic [5:0]    lsu_wfid,
  output logic          trace_valid,
  output logic [2:0]    trace_unit,
  output logic [5:0]    trace_wfid,
  output logic [31:0]   trace_pc,
  output logic [31:0]   trace_instr,
  output logic [8:0]    trace_sgpr_base,
  output logic [9:0]    trace_vgpr_base,
  output logic [9:0]    trace_lds_base,
  output logic          trace_miss,
  output logic          trace_dest_en,
  output logic          trace_dest_vgpr,
  output logic [9:0]    trace_dest_addr,
  output logic [31:0]   trace_dest_data,
  output logic [63:0]   trace_dest_mask,
  output logic          trace_vcc_en,
  output logic [63:0]   trace_vcc_value,
  output logic          trace_exec_en,
  output logic [63:0]   trace_exec_value,
  output logic          trace_scc_en,
  output logic          trace_scc_value,
  output logic [31:0]   trace_mem_addr,
  output logic [31:0]   trace_mem_data,
  output logic          overflow_err,
  output logic          table_full_err
`ifdef TRACEMON_HALT_CHECK_EN
  ,
  output logic          halt_err
`endif
);

  localparam int NU = 6;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [5:0]  wfid;
    logic [31:0] pc;
    logic        dest_en;
    logic        dest_vgpr;
    logic [9:0]  dest_addr;
    logic [31:0] dest_data;
    logic [63:0] dest_mask;
    logic        vcc_en;
    logic [63:0] vcc_value;
    logic        exec_en;
    logic [63:0] exec_value;
    logic        scc_en;
    logic        scc_value;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
  } rec_t;

  typedef struct packed {
    logic [5:0]  wfid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [8:0]  sgpr_base;
    logic [9:0]  vgpr_base;
    logic [9:0]  lds_base;
  } entry_t;

  function automatic rec_t simd_rec(input logic [5:0] wfid, input logic [31:0] pc,
                                    input logic vcc_en, input logic [63:0] vcc_value,
                                    input logic wr_en, input logic [9:0] addr,
                                    input logic [31:0] data, input logic [63:0] mask);
    rec_t r;
    r           = '0;
    r.wfid      = wfid;
    r.pc        = pc;
    r.vcc_en    = vcc_en;
    r.vcc_value = vcc_en ? vcc_value : 64'd0;
    if (wr_en) begin
      r.dest_en   = 1'b1;
      r.dest_vgpr = 1'b1;
      r.dest_addr = addr;
      r.dest_data = data;
      r.dest_mask = mask;
    end
    return r;
  endfunction

  rec_t             cap [NU];
  logic [NU-1:0]    cap_vld;
  rec_t             slot_q [NU];
  logic [NU-1:0]    occ_q;
  logic [NU-1:0]    svc;
  logic             sel_vld;
  logic [2:0]       sel_u;
  rec_t             sel_rec;
  entry_t           tbl_q [DEPTH];
  entry_t           hit_entry;
  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] vld_d;
  logic             hit;
  logic [IW-1:0]    hit_idx;
  logic             free_found;
  logic [IW-1:0]    free_idx;
  logic [DEPTH-1:0] halt_kill;
  logic             unused_bits;

  // Only lane 0 of the wide data buses is traced.
  assign unused_bits = ^{simd12vgpr_dest_data[2047:32], simd22vgpr_dest_data[2047:32],
                         simd32vgpr_dest_data[2047:32], simd42vgpr_dest_data[2047:32],
                         lsu2vgpr_dest_data[2047:32], lsu_addr[2047:32], lsu_store_data[2047:32]};

  always_comb begin
    cap_vld = {lsu_retire_valid, simd4_retire_valid, simd3_retire_valid,
               simd2_retire_valid, simd1_retire_valid, salu_retire_valid};

    cap[0]            = '0;
    cap[0].wfid       = salu_wfid;
    cap[0].pc         = salu_retire_pc;
    cap[0].exec_en    = salu2exec_wr_exec_en;
    cap[0].exec_value = salu2exec_wr_exec_en ? salu2exec_wr_exec_value : 64'd0;
    cap[0].vcc_en     = salu2exec_wr_vcc_en;
    cap[0].vcc_value  = salu2exec_wr_vcc_en ? salu2exec_wr_vcc_value : 64'd0;
    cap[0].scc_en     = salu_wr_scc_en;
    cap[0].scc_value  = salu_wr_scc_en & salu_wr_scc_value;
    if (salu2sgpr_dest_wr_en) begin
      cap[0].dest_en   = 1'b1;
      cap[0].dest_addr = {1'b0, salu2sgpr_dest_addr};
      cap[0].dest_data = salu2sgpr_dest_data;
    end

    cap[1] = simd_rec(simd1_wfid, simd1_retire_pc, simd12exec_wr_vcc_en, simd12exec_wr_vcc_value,
                      simd12vgpr_dest_wr_en, simd12vgpr_dest_addr, simd12vgpr_dest_data[31:0],
                      simd12vgpr_wr_mask);
    cap[2] = simd_rec(simd2_wfid, simd2_retire_pc, simd22exec_wr_vcc_en, simd22exec_wr_vcc_value,
                      simd22vgpr_dest_wr_en, simd22vgpr_dest_addr, simd22vgpr_dest_data[31:0],
                      simd22vgpr_wr_mask);
    cap[3] = simd_rec(simd3_wfid, simd3_retire_pc, simd32exec_wr_vcc_en, simd32exec_wr_vcc_value,
                      simd32vgpr_dest_wr_en, simd32vgpr_dest_addr, simd32vgpr_dest_data[31:0],
                      simd32vgpr_wr_mask);
    cap[4] = simd_rec(simd4_wfid, simd4_retire_pc, simd42exec_wr_vcc_en, simd42exec_wr_vcc_value,
                      simd42vgpr_dest_wr_en, simd42vgpr_dest_addr, simd42vgpr_dest_data[31:0],
                      simd42vgpr_wr_mask);

    // LSU: an SGPR write takes precedence over a VGPR write.
    cap[5]          = '0;
    cap[5].wfid     = lsu_wfid;
    cap[5].pc       = lsu_retire_pc;
    cap[5].mem_addr = lsu_addr[31:0];
    cap[5].mem_data = lsu_store_data[31:0];
    if (lsu2sgpr_dest_wr_en) begin
      cap[5].dest_en   = 1'b1;
      cap[5].dest_addr = {1'b0, lsu2sgpr_dest_addr};
      cap[5].dest_data = lsu2sgpr_dest_data;
    end else if (lsu2vgpr_dest_wr_en) begin
      cap[5].dest_en   = 1'b1;
      cap[5].dest_vgpr = 1'b1;
      cap[5].dest_addr = lsu_dest_str_addr;
      cap[5].dest_data = lsu2vgpr_dest_data[31:0];
      cap[5].dest_mask = lsu_dest_str_mask;
    end
  end

  // Descending scans so the lowest index wins.
  always_comb begin
    sel_vld = 1'b0;
    sel_u   = 3'd0;
    sel_rec = '0;
    svc     = '0;
    for (int u = NU - 1; u >= 0; u--) begin
      if (occ_q[u]) begin
        sel_vld = 1'b1;
        sel_u   = 3'(u);
        sel_rec = slot_q[u];
        svc     = '0;
        svc[u]  = 1'b1;
      end
    end
  end

  always_comb begin
    hit        = 1'b0;
    hit_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int e = DEPTH - 1; e >= 0; e--) begin
      if (sel_vld && vld_q[e] && tbl_q[e].wfid == sel_rec.wfid && tbl_q[e].pc == sel_rec.pc) begin
        hit     = 1'b1;
        hit_idx = IW'(e);
      end
      if (!vld_q[e]) begin
        free_found = 1'b1;
        free_idx   = IW'(e);
      end
    end
    hit_entry = tbl_q[hit_idx];
  end

`ifdef TRACEMON_HALT_CHECK_EN
  always_comb begin
    halt_kill = '0;
    for (int e = 0; e < DEPTH; e++) begin
      halt_kill[e] = issue_halt && vld_q[e] && (tbl_q[e].wfid == issue_halt_wfid);
    end
  end
`else
  logic unused_halt;
  assign halt_kill   = '0;
  assign unused_halt = ^{issue_halt, issue_halt_wfid};
`endif

  // Allocation uses the pre-edge valid vector; a same-edge free is reusable next cycle.
  always_comb begin
    vld_d = vld_q & ~halt_kill;
    if (hit) vld_d[hit_idx] = 1'b0;
    if (wave2decode_instr_valid && free_found) vld_d[free_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (wave2decode_instr_valid && free_found) begin
      tbl_q[free_idx] <= '{wfid: wave2decode_wfid, pc: wave2decode_instr_pc,
                           instr: wave2decode_instr, sgpr_base: wave2decode_sgpr_base,
                           vgpr_base: wave2decode_vgpr_base, lds_base: wave2decode_lds_base};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_q            <= '0;
      occ_q            <= '0;
      for (int u = 0; u < NU; u++) slot_q[u] <= '0;
      trace_valid      <= 1'b0;
      trace_unit       <= '0;
      trace_wfid       <= '0;
      trace_pc         <= '0;
      trace_instr      <= '0;
      trace_sgpr_base  <= '0;
      trace_vgpr_base  <= '0;
      trace_lds_base   <= '0;
      trace_miss       <= 1'b0;
      trace_dest_en    <= 1'b0;
      trace_dest_vgpr  <= 1'b0;
      trace_dest_addr  <= '0;
      trace_dest_data  <= '0;
      trace_dest_mask  <= '0;
      trace_vcc_en     <= 1'b0;
      trace_vcc_value  <= '0;
      trace_exec_en    <= 1'b0;
      trace_exec_value <= '0;
      trace_scc_en     <= 1'b0;
      trace_scc_value  <= 1'b0;
      trace_mem_addr   <= '0;
      trace_mem_data   <= '0;
      overflow_err     <= 1'b0;
      table_full_err   <= 1'b0;
`ifdef TRACEMON_HALT_CHECK_EN
      halt_err         <= 1'b0;
`endif
    end else begin
      vld_q <= vld_d;
      for (int u = 0; u < NU; u++) begin
        if (cap_vld[u]) begin
          slot_q[u] <= cap[u];
          occ_q[u]  <= 1'b1;
          if (occ_q[u] && !svc[u]) overflow_err <= 1'b1;
        end else if (svc[u]) begin
          occ_q[u] <= 1'b0;
        end
      end
      if (wave2decode_instr_valid && !free_found) table_full_err <= 1'b1;
`ifdef TRACEMON_HALT_CHECK_EN
      if (|halt_kill) halt_err <= 1'b1;
`endif
      trace_valid <= sel_vld;
      if (sel_vld) begin
        trace_unit       <= sel_u;
        trace_wfid       <= sel_rec.wfid;
        trace_pc         <= sel_rec.pc;
        trace_miss       <= !hit;
        trace_instr      <= hit ? hit_entry.instr : 32'd0;
        trace_sgpr_base  <= hit ? hit_entry.sgpr_base : 9'd0;
        trace_vgpr_base  <= hit ? hit_entry.vgpr_base : 10'd0;
        trace_lds_base   <= hit ? hit_entry.lds_base : 10'd0;
        trace_dest_en    <= sel_rec.dest_en;
        trace_dest_vgpr  <= sel_rec.dest_vgpr;
        trace_dest_addr  <= sel_rec.dest_addr;
        trace_dest_data  <= sel_rec.dest_data;
        trace_dest_mask  <= sel_rec.dest_mask;
        trace_vcc_en     <= sel_rec.vcc_en;
        trace_vcc_value  <= sel_rec.vcc_value;
        trace_exec_en    <= sel_rec.exec_en;
        trace_exec_value <= sel_rec.exec_value;
        trace_scc_en     <= sel_rec.scc_en;
        trace_scc_value  <= sel_rec.scc_value;
        trace_mem_addr   <= sel_rec.mem_addr;
        trace_mem_data   <= sel_rec.mem_data;
      end
    end
  end

endmodule

// File: tb/tb_trace_monitor.sv
// Bench for trace_monitor: directed scenarios, then randomized traffic against a reference model.
module tb_trace_monitor;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          wave2decode_instr_valid;
  logic [31:0]   wave2decode_instr, wave2decode_instr_pc;
  logic [8:0]    wave2decode_sgpr_base;
  logic [9:0]    wave2decode_vgpr_base, wave2decode_lds_base;
  logic [5:0]    wave2decode_wfid;
  logic          salu2exec_wr_exec_en, salu2exec_wr_vcc_en, salu_wr_scc_en, salu_wr_scc_value;
  logic [63:0]   salu2exec_wr_exec_value, salu2exec_wr_vcc_value;
  logic          salu2sgpr_dest_wr_en;
  logic [8:0]    salu2sgpr_dest_addr;
  logic [31:0]   salu2sgpr_dest_data;
  logic          simd12exec_wr_vcc_en, simd22exec_wr_vcc_en, simd32exec_wr_vcc_en, simd42exec_wr_vcc_en;
  logic [63:0]   simd12exec_wr_vcc_value, simd22exec_wr_vcc_value, simd32exec_wr_vcc_value, simd42exec_wr_vcc_value;
  logic          simd12vgpr_dest_wr_en, simd22vgpr_dest_wr_en, simd32vgpr_dest_wr_en, simd42vgpr_dest_wr_en;
  logic [9:0]    simd12vgpr_dest_addr, simd22vgpr_dest_addr, simd32vgpr_dest_addr, simd42vgpr_dest_addr;
  logic [2047:0] simd12vgpr_dest_data, simd22vgpr_dest_data, simd32vgpr_dest_data, simd42vgpr_dest_data;
  logic [63:0]   simd12vgpr_wr_mask, simd22vgpr_wr_mask, simd32vgpr_wr_mask, simd42vgpr_wr_mask;
  logic          lsu2sgpr_dest_wr_en, lsu2vgpr_dest_wr_en;
  logic [8:0]    lsu2sgpr_dest_addr;
  logic [31:0]   lsu2sgpr_dest_data;
  logic [2047:0] lsu2vgpr_dest_data, lsu_addr, lsu_store_data;
  logic [9:0]    lsu_dest_str_addr;
  logic [63:0]   lsu_dest_str_mask;
  logic          issue_halt;
  logic [5:0]    issue_halt_wfid;
  logic          salu_retire_valid, simd1_retire_valid, simd2_retire_valid, simd3_retire_valid, simd4_retire_valid, lsu_retire_valid;
  logic [31:0]   salu_retire_pc, simd1_retire_pc, simd2_retire_pc, simd3_retire_pc, simd4_retire_pc, lsu_retire_pc;
  logic [5:0]    salu_wfid, simd1_wfid, simd2_wfid, simd3_wfid, simd4_wfid, lsu_wfid;

  logic          trace_valid, trace_miss, trace_dest_en, trace_dest_vgpr;
  logic [2:0]    trace_unit;
  logic [5:0]    trace_wfid;
  logic [31:0]   trace_pc, trace_instr, trace_dest_data, trace_mem_addr, trace_mem_data;
  logic [8:0]    trace_sgpr_base;
  logic [9:0]    trace_vgpr_base, trace_lds_base, trace_dest_addr;
  logic [63:0]   trace_dest_mask, trace_vcc_value, trace_exec_value;
  logic          trace_vcc_en, trace_exec_en, trace_scc_en, trace_scc_value;
  logic          overflow_err, table_full_err;
`ifdef TRACEMON_HALT_CHECK_EN
  logic          halt_err;
`endif

  trace_monitor #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .wave2decode_instr_valid(wave2decode_instr_valid), .wave2decode_instr(wave2decode_instr),
    .wave2decode_instr_pc(wave2decode_instr_pc), .wave2decode_sgpr_base(wave2decode_sgpr_base),
    .wave2decode_vgpr_base(wave2decode_vgpr_base), .wave2decode_lds_base(wave2decode_lds_base),
    .wave2decode_wfid(wave2decode_wfid),
    .salu2exec_wr_exec_en(salu2exec_wr_exec_en), .salu2exec_wr_exec_value(salu2exec_wr_exec_value),
    .salu2exec_wr_vcc_en(salu2exec_wr_vcc_en), .salu2exec_wr_vcc_value(salu2exec_wr_vcc_value),
    .salu_wr_scc_en(salu_wr_scc_en), .salu_wr_scc_value(salu_wr_scc_value),
    .salu2sgpr_dest_wr_en(salu2sgpr_dest_wr_en), .salu2sgpr_dest_addr(salu2sgpr_dest_addr),
    .salu2sgpr_dest_data(salu2sgpr_dest_data),
    .simd12exec_wr_vcc_en(simd12exec_wr_vcc_en), .simd12exec_wr_vcc_value(simd12exec_wr_vcc_value),
    .simd12vgpr_dest_wr_en(simd12vgpr_dest_wr_en), .simd12vgpr_dest_addr(simd12vgpr_dest_addr),
    .simd12vgpr_dest_data(simd12vgpr_dest_data), .simd12vgpr_wr_mask(simd12vgpr_wr_mask),
    .simd22exec_wr_vcc_en(simd22exec_wr_vcc_en), .simd22exec_wr_vcc_value(simd22exec_wr_vcc_value),
    .simd22vgpr_dest_wr_en(simd22vgpr_dest_wr_en), .simd22vgpr_dest_addr(simd22vgpr_dest_addr),
    .simd22vgpr_dest_data(simd22vgpr_dest_data), .simd22vgpr_wr_mask(simd22vgpr_wr_mask),
    .simd32exec_wr_vcc_en(simd32exec_wr_vcc_en), .simd32exec_wr_vcc_value(simd32exec_wr_vcc_value),
    .simd32vgpr_dest_wr_en(simd32vgpr_dest_wr_en), .simd32vgpr_dest_addr(simd32vgpr_dest_addr),
    .simd32vgpr_dest_data(simd32vgpr_dest_data), .simd32vgpr_wr_mask(simd32vgpr_wr_mask),
    .simd42exec_wr_vcc_en(simd42exec_wr_vcc_en), .simd42exec_wr_vcc_value(simd42exec_wr_vcc_value),
    .simd42vgpr_dest_wr_en(simd42vgpr_dest_wr_en), .simd42vgpr_dest_addr(simd42vgpr_dest_addr),
    .simd42vgpr_dest_data(simd42vgpr_dest_data), .simd42vgpr_wr_mask(simd42vgpr_wr_mask),
    .lsu2sgpr_dest_wr_en(lsu2sgpr_dest_wr_en), .lsu2sgpr_dest_addr(lsu2sgpr_dest_addr),
    .lsu2sgpr_dest_data(lsu2sgpr_dest_data), .lsu2vgpr_dest_wr_en(lsu2vgpr_dest_wr_en),
    .lsu2vgpr_dest_data(lsu2vgpr_dest_data), .lsu_dest_str_addr(lsu_dest_str_addr),
    .lsu_dest_str_mask(lsu_dest_str_mask), .lsu_addr(lsu_addr), .lsu_store_data(lsu_store_data),
    .issue_halt(issue_halt), .issue_halt_wfid(issue_halt_wfid),
    .salu_retire_valid(salu_retire_valid), .salu_retire_pc(salu_retire_pc), .salu_wfid(salu_wfid),
    .simd1_retire_valid(simd1_retire_valid), .simd1_retire_pc(simd1_retire_pc), .simd1_wfid(simd1_wfid),
    .simd2_retire_valid(simd2_retire_valid), .simd2_retire_pc(simd2_retire_pc), .simd2_wfid(simd2_wfid),
    .simd3_retire_valid(simd3_retire_valid), .simd3_retire_pc(simd3_retire_pc), .simd3_wfid(simd3_wfid),
    .simd4_retire_valid(simd4_retire_valid), .simd4_retire_pc(simd4_retire_pc), .simd4_wfid(simd4_wfid),
    .lsu_retire_valid(lsu_retire_valid), .lsu_retire_pc(lsu_retire_pc), .lsu_wfid(lsu_wfid),
    .trace_valid(trace_valid), .trace_unit(trace_unit), .trace_wfid(trace_wfid), .trace_pc(trace_pc),
    .trace_instr(trace_instr), .trace_sgpr_base(trace_sgpr_base), .trace_vgpr_base(trace_vgpr_base),
    .trace_lds_base(trace_lds_base), .trace_miss(trace_miss), .trace_dest_en(trace_dest_en),
    .trace_dest_vgpr(trace_dest_vgpr), .trace_dest_addr(trace_dest_addr), .trace_dest_data(trace_dest_data),
    .trace_dest_mask(trace_dest_mask), .trace_vcc_en(trace_vcc_en), .trace_vcc_value(trace_vcc_value),
    .trace_exec_en(trace_exec_en), .trace_exec_value(trace_exec_value), .trace_scc_en(trace_scc_en),
    .trace_scc_value(trace_scc_value), .trace_mem_addr(trace_mem_addr), .trace_mem_data(trace_mem_data),
    .overflow_err(overflow_err), .table_full_err(table_full_err)
`ifdef TRACEMON_HALT_CHECK_EN
    , .halt_err(halt_err)
`endif
  );

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    wave2decode_instr_valid = 0; wave2decode_instr = 0; wave2decode_instr_pc = 0;
    wave2decode_sgpr_base = 0; wave2decode_vgpr_base = 0; wave2decode_lds_base = 0; wave2decode_wfid = 0;
    salu2exec_wr_exec_en = 0; salu2exec_wr_exec_value = 0; salu2exec_wr_vcc_en = 0; salu2exec_wr_vcc_value = 0;
    salu_wr_scc_en = 0; salu_wr_scc_value = 0;
    salu2sgpr_dest_wr_en = 0; salu2sgpr_dest_addr = 0; salu2sgpr_dest_data = 0;
    simd12exec_wr_vcc_en = 0; simd12exec_wr_vcc_value = 0; simd12vgpr_dest_wr_en = 0;
    simd12vgpr_dest_addr = 0; simd12vgpr_dest_data = 0; simd12vgpr_wr_mask = 0;
    simd22exec_wr_vcc_en = 0; simd22exec_wr_vcc_value = 0; simd22vgpr_dest_wr_en = 0;
    simd22vgpr_dest_addr = 0; simd22vgpr_dest_data = 0; simd22vgpr_wr_mask = 0;
    simd32exec_wr_vcc_en = 0; simd32exec_wr_vcc_value = 0; simd32vgpr_dest_wr_en = 0;
    simd32vgpr_dest_addr = 0; simd32vgpr_dest_data = 0; simd32vgpr_wr_mask = 0;
    simd42exec_wr_vcc_en = 0; simd42exec_wr_vcc_value = 0; simd42vgpr_dest_wr_en = 0;
    simd42vgpr_dest_addr = 0; simd42vgpr_dest_data = 0; simd42vgpr_wr_mask = 0;
    lsu2sgpr_dest_wr_en = 0; lsu2sgpr_dest_addr = 0; lsu2sgpr_dest_data = 0;
    lsu2vgpr_dest_wr_en = 0; lsu2vgpr_dest_data = 0; lsu_dest_str_addr = 0; lsu_dest_str_mask = 0;
    lsu_addr = 0; lsu_store_data = 0; issue_halt = 0; issue_halt_wfid = 0;
    salu_retire_valid = 0; salu_retire_pc = 0; salu_wfid = 0;
    simd1_retire_valid = 0; simd1_retire_pc = 0; simd1_wfid = 0;
    simd2_retire_valid = 0; simd2_retire_pc = 0; simd2_wfid = 0;
    simd3_retire_valid = 0; simd3_retire_pc = 0; simd3_wfid = 0;
    simd4_retire_valid = 0; simd4_retire_pc = 0; simd4_wfid = 0;
    lsu_retire_valid = 0; lsu_retire_pc = 0; lsu_wfid = 0;
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [5:0] wfid; logic [31:0] pc; logic den; logic dvgpr; logic [9:0] daddr;
    logic [31:0] ddata; logic [63:0] dmask; logic vcc_en; logic [63:0] vcc;
    logic exec_en; logic [63:0] exec_v; logic scc_en; logic scc; logic [31:0] maddr; logic [31:0] mdata;
  } mrec_t;
  typedef struct packed {
    logic v; logic [5:0] wfid; logic [31:0] pc; logic [31:0] instr; logic [8:0] sb; logic [9:0] vb; logic [9:0] lb;
  } ment_t;

  ment_t m_tbl [DEPTH];
  mrec_t m_slot [6];
  bit    m_occ [6];
  mrec_t e_rec;
  logic  e_valid, e_miss, e_ovf, e_full;
  logic [2:0] e_unit;
  logic [31:0] e_instr;
  logic [8:0] e_sb;
  logic [9:0] e_vb, e_lb;

  task automatic model_reset();
    for (int e = 0; e < DEPTH; e++) m_tbl[e] = '0;
    for (int u = 0; u < 6; u++) begin m_slot[u] = '0; m_occ[u] = 0; end
    e_rec = '0; e_valid = 0; e_miss = 0; e_ovf = 0; e_full = 0; e_unit = 0;
    e_instr = 0; e_sb = 0; e_vb = 0; e_lb = 0;
  endtask

  function automatic mrec_t vgpr_event(logic [5:0] w, logic [31:0] pc, logic ven, logic [63:0] vv,
                                      logic en, logic [9:0] a, logic [31:0] d, logic [63:0] m);
    mrec_t r = '0;
    r.wfid = w; r.pc = pc; r.vcc_en = ven; r.vcc = ven ? vv : 64'd0;
    if (en) begin r.den = 1; r.dvgpr = 1; r.daddr = a; r.ddata = d; r.dmask = m; end
    return r;
  endfunction

  function automatic mrec_t capture(int u);
    mrec_t r = '0;
    case (u)
      0: begin
        r.wfid = salu_wfid; r.pc = salu_retire_pc;
        r.exec_en = salu2exec_wr_exec_en; r.exec_v = salu2exec_wr_exec_en ? salu2exec_wr_exec_value : 64'd0;
        r.vcc_en = salu2exec_wr_vcc_en; r.vcc = salu2exec_wr_vcc_en ? salu2exec_wr_vcc_value : 64'd0;
        r.scc_en = salu_wr_scc_en; r.scc = salu_wr_scc_en ? salu_wr_scc_value : 1'b0;
        if (salu2sgpr_dest_wr_en) begin
          r.den = 1; r.daddr = {1'b0, salu2sgpr_dest_addr}; r.ddata = salu2sgpr_dest_data;
        end
      end
      1: r = vgpr_event(simd1_wfid, simd1_retire_pc, simd12exec_wr_vcc_en, simd12exec_wr_vcc_value,
                        simd12vgpr_dest_wr_en, simd12vgpr_dest_addr, simd12vgpr_dest_data[31:0], simd12vgpr_wr_mask);
      2: r = vgpr_event(simd2_wfid, simd2_retire_pc, simd22exec_wr_vcc_en, simd22exec_wr_vcc_value,
                        simd22vgpr_dest_wr_en, simd22vgpr_dest_addr, simd22vgpr_dest_data[31:0], simd22vgpr_wr_mask);
      3: r = vgpr_event(simd3_wfid, simd3_retire_pc, simd32exec_wr_vcc_en, simd32exec_wr_vcc_value,
                        simd32vgpr_dest_wr_en, simd32vgpr_dest_addr, simd32vgpr_dest_data[31:0], simd32vgpr_wr_mask);
      4: r = vgpr_event(simd4_wfid, simd4_retire_pc, simd42exec_wr_vcc_en, simd42exec_wr_vcc_value,
                        simd42vgpr_dest_wr_en, simd42vgpr_dest_addr, simd42vgpr_dest_data[31:0], simd42vgpr_wr_mask);
      default: begin
        r.wfid = lsu_wfid; r.pc = lsu_retire_pc; r.maddr = lsu_addr[31:0]; r.mdata = lsu_store_data[31:0];
        if (lsu2sgpr_dest_wr_en) begin
          r.den = 1; r.daddr = {1'b0, lsu2sgpr_dest_addr}; r.ddata = lsu2sgpr_dest_data;
        end else if (lsu2vgpr_dest_wr_en) begin
          r.den = 1; r.dvgpr = 1; r.daddr = lsu_dest_str_addr; r.ddata = lsu2vgpr_dest_data[31:0];
          r.dmask = lsu_dest_str_mask;
        end
      end
    endcase
    return r;
  endfunction

  // Advance the model across one clock edge using the inputs currently applied.
  task automatic model_edge();
    int svc, hit, fr;
    bit ret [6];
    ret[0] = salu_retire_valid;  ret[1] = simd1_retire_valid; ret[2] = simd2_retire_valid;
    ret[3] = simd3_retire_valid; ret[4] = simd4_retire_valid; ret[5] = lsu_retire_valid;
    svc = -1; hit = -1; fr = -1;
    for (int u = 0; u < 6; u++) if (svc < 0 && m_occ[u]) svc = u;
    e_valid = (svc >= 0);
    if (svc >= 0) begin
      for (int e = 0; e < DEPTH; e++)
        if (hit < 0 && m_tbl[e].v && m_tbl[e].wfid == m_slot[svc].wfid && m_tbl[e].pc == m_slot[svc].pc) hit = e;
      e_rec  = m_slot[svc];
      e_unit = 3'(svc);
      e_miss = (hit < 0);
      e_instr = (hit >= 0) ? m_tbl[hit].instr : 32'd0;
      e_sb    = (hit >= 0) ? m_tbl[hit].sb : 9'd0;
      e_vb    = (hit >= 0) ? m_tbl[hit].vb : 10'd0;
      e_lb    = (hit >= 0) ? m_tbl[hit].lb : 10'd0;
    end
    if (wave2decode_instr_valid) begin
      for (int e = 0; e < DEPTH; e++) if (fr < 0 && !m_tbl[e].v) fr = e;
      if (fr < 0) e_full = 1;
      else m_tbl[fr] = '{v: 1'b1, wfid: wave2decode_wfid, pc: wave2decode_instr_pc, instr: wave2decode_instr,
                         sb: wave2decode_sgpr_base, vb: wave2decode_vgpr_base, lb: wave2decode_lds_base};
    end
    if (hit >= 0) m_tbl[hit].v = 0;
    for (int u = 0; u < 6; u++) begin
      if (ret[u]) begin
        if (m_occ[u] && u != svc) e_ovf = 1;
        m_slot[u] = capture(u);
        m_occ[u] = 1;
      end else if (u == svc) begin
        m_occ[u] = 0;
      end
    end
  endtask

  task automatic compare_all();
    chk("valid", trace_valid, e_valid);       chk("unit", trace_unit, e_unit);
    chk("wfid", trace_wfid, e_rec.wfid);      chk("pc", trace_pc, e_rec.pc);
    chk("instr", trace_instr, e_instr);       chk("miss", trace_miss, e_miss);
    chk("sgpr_base", trace_sgpr_base, e_sb);  chk("vgpr_base", trace_vgpr_base, e_vb);
    chk("lds_base", trace_lds_base, e_lb);    chk("dest_en", trace_dest_en, e_rec.den);
    chk("dest_vgpr", trace_dest_vgpr, e_rec.dvgpr); chk("dest_addr", trace_dest_addr, e_rec.daddr);
    chk("dest_data", trace_dest_data, e_rec.ddata); chk("dest_mask", trace_dest_mask, e_rec.dmask);
    chk("vcc_en", trace_vcc_en, e_rec.vcc_en);      chk("vcc", trace_vcc_value, e_rec.vcc);
    chk("exec_en", trace_exec_en, e_rec.exec_en);   chk("exec", trace_exec_value, e_rec.exec_v);
    chk("scc_en", trace_scc_en, e_rec.scc_en);      chk("scc", trace_scc_value, e_rec.scc);
    chk("mem_addr", trace_mem_addr, e_rec.maddr);   chk("mem_data", trace_mem_data, e_rec.mdata);
    chk("overflow_err", overflow_err, e_ovf);       chk("table_full_err", table_full_err, e_full);
  endtask

  function automatic logic [2047:0] wide_rand();
    logic [2047:0] w;
    for (int k = 0; k < 64; k++) w[k*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic random_inputs();
    wave2decode_instr_valid = ($urandom_range(0, 9) < 4);
    wave2decode_wfid = 6'($urandom_range(0, 3)); wave2decode_instr_pc = $urandom_range(0, 7);
    wave2decode_instr = $urandom; wave2decode_sgpr_base = 9'($urandom);
    wave2decode_vgpr_base = 10'($urandom); wave2decode_lds_base = 10'($urandom);
    salu2exec_wr_exec_en = 1'($urandom); salu2exec_wr_exec_value = {$urandom, $urandom};
    salu2exec_wr_vcc_en = 1'($urandom); salu2exec_wr_vcc_value = {$urandom, $urandom};
    salu_wr_scc_en = 1'($urandom); salu_wr_scc_value = 1'($urandom);
    salu2sgpr_dest_wr_en = 1'($urandom); salu2sgpr_dest_addr = 9'($urandom); salu2sgpr_dest_data = $urandom;
    simd12exec_wr_vcc_en = 1'($urandom); simd12exec_wr_vcc_value = {$urandom, $urandom};
    simd12vgpr_dest_wr_en = 1'($urandom); simd12vgpr_dest_addr = 10'($urandom);
    simd12vgpr_dest_data = wide_rand(); simd12vgpr_wr_mask = {$urandom, $urandom};
    simd22exec_wr_vcc_en = 1'($urandom); simd22exec_wr_vcc_value = {$urandom, $urandom};
    simd22vgpr_dest_wr_en = 1'($urandom); simd22vgpr_dest_addr = 10'($urandom);
    simd22vgpr_dest_data = wide_rand(); simd22vgpr_wr_mask = {$urandom, $urandom};
    simd32exec_wr_vcc_en = 1'($urandom); simd32exec_wr_vcc_value = {$urandom, $urandom};
    simd32vgpr_dest_wr_en = 1'($urandom); simd32vgpr_dest_addr = 10'($urandom);
    simd32vgpr_dest_data = wide_rand(); simd32vgpr_wr_mask = {$urandom, $urandom};
    simd42exec_wr_vcc_en = 1'($urandom); simd42exec_wr_vcc_value = {$urandom, $urandom};
    simd42vgpr_dest_wr_en = 1'($urandom); simd42vgpr_dest_addr = 10'($urandom);
    simd42vgpr_dest_data = wide_rand(); simd42vgpr_wr_mask = {$urandom, $urandom};
    lsu2sgpr_dest_wr_en = 1'($urandom); lsu2sgpr_dest_addr = 9'($urandom); lsu2sgpr_dest_data = $urandom;
    lsu2vgpr_dest_wr_en = 1'($urandom); lsu2vgpr_dest_data = wide_rand();
    lsu_dest_str_addr = 10'($urandom); lsu_dest_str_mask = {$urandom, $urandom};
    lsu_addr = wide_rand(); lsu_store_data = wide_rand();
    salu_retire_valid  = ($urandom_range(0, 99) < 15); salu_wfid  = 6'($urandom_range(0, 3)); salu_retire_pc  = $urandom_range(0, 7);
    simd1_retire_valid = ($urandom_range(0, 99) < 15); simd1_wfid = 6'($urandom_range(0, 3)); simd1_retire_pc = $urandom_range(0, 7);
    simd2_retire_valid = ($urandom_range(0, 99) < 15); simd2_wfid = 6'($urandom_range(0, 3)); simd2_retire_pc = $urandom_range(0, 7);
    simd3_retire_valid = ($urandom_range(0, 99) < 15); simd3_wfid = 6'($urandom_range(0, 3)); simd3_retire_pc = $urandom_range(0, 7);
    simd4_retire_valid = ($urandom_range(0, 99) < 15); simd4_wfid = 6'($urandom_range(0, 3)); simd4_retire_pc = $urandom_range(0, 7);
    lsu_retire_valid   = ($urandom_range(0, 99) < 15); lsu_wfid   = 6'($urandom_range(0, 3)); lsu_retire_pc   = $urandom_range(0, 7);
  endtask

  initial begin
    clear_inputs();
    rst = 0;
    tick(); tick();
    chk("rst_valid", trace_valid, 0);   chk("rst_pc", trace_pc, 0);   chk("rst_instr", trace_instr, 0);
    chk("rst_unit", trace_unit, 0);     chk("rst_ovf", overflow_err, 0); chk("rst_full", table_full_err, 0);
`ifdef TRACEMON_HALT_CHECK_EN
    chk("rst_halt", halt_err, 0);
`endif
    rst = 1;

    // Issue three instructions of wave 0.
    for (int i = 0; i < 3; i++) begin
      wave2decode_instr_valid = 1; wave2decode_instr_pc = i; wave2decode_instr = 10 * (i + 1);
      wave2decode_sgpr_base = 1; wave2decode_vgpr_base = 2; wave2decode_lds_base = 3; wave2decode_wfid = 0;
      tick();
    end
    clear_inputs();
    lsu_retire_valid = 1; lsu_retire_pc = 0; lsu_wfid = 0; lsu2vgpr_dest_wr_en = 1;
    lsu_dest_str_addr = 6; lsu_dest_str_mask = 7; lsu2vgpr_dest_data[31:0] = 15;
    lsu_addr[63:0] = 64'h0000123400005678;
    tick();
    chk("lsu_lat_valid", trace_valid, 0);
    clear_inputs();
    tick();
    chk("lsu_valid", trace_valid, 1);   chk("lsu_unit", trace_unit, 5);   chk("lsu_instr", trace_instr, 10);
    chk("lsu_dvgpr", trace_dest_vgpr, 1); chk("lsu_daddr", trace_dest_addr, 6); chk("lsu_ddata", trace_dest_data, 15);
    chk("lsu_dmask", trace_dest_mask, 7); chk("lsu_maddr", trace_mem_addr, 32'h5678);
    chk("lsu_sb", trace_sgpr_base, 1);  chk("lsu_vb", trace_vgpr_base, 2); chk("lsu_lb", trace_lds_base, 3);
    chk("lsu_miss", trace_miss, 0);
    tick();
    chk("idle_valid", trace_valid, 0);  chk("idle_hold_instr", trace_instr, 10);

    simd3_retire_valid = 1; simd3_retire_pc = 2; simd3_wfid = 0;
    simd4_retire_valid = 1; simd4_retire_pc = 1; simd4_wfid = 0;
    simd42exec_wr_vcc_en = 1; simd42exec_wr_vcc_value = 2;
    tick();
    clear_inputs();
    tick();
    chk("s3_valid", trace_valid, 1); chk("s3_unit", trace_unit, 3); chk("s3_instr", trace_instr, 30);
    tick();
    chk("s4_valid", trace_valid, 1); chk("s4_unit", trace_unit, 4); chk("s4_instr", trace_instr, 20);
    chk("s4_vcc_en", trace_vcc_en, 1); chk("s4_vcc", trace_vcc_value, 2);

    salu_retire_valid = 1; salu_retire_pc = 0; salu_wfid = 0;
    salu2sgpr_dest_wr_en = 1; salu2sgpr_dest_addr = 4; salu2sgpr_dest_data = 23;
    salu_wr_scc_en = 1; salu_wr_scc_value = 1;
    tick();
    clear_inputs();
    tick();
    chk("salu_unit", trace_unit, 0);   chk("salu_miss", trace_miss, 1); chk("salu_instr", trace_instr, 0);
    chk("salu_ddata", trace_dest_data, 23); chk("salu_daddr", trace_dest_addr, 4);
    chk("salu_scc", trace_scc_value, 1); chk("salu_dvgpr", trace_dest_vgpr, 0);

    // Back-to-back reload of a slot that is being serviced is not an overflow.
    salu_retire_valid = 1; salu_retire_pc = 40;
    tick(); tick();
    clear_inputs();
    chk("reload_valid", trace_valid, 1); chk("reload_ovf", overflow_err, 0);
    tick();
    chk("reload2_valid", trace_valid, 1);
    tick();

    for (int i = 0; i < DEPTH; i++) begin
      wave2decode_instr_valid = 1; wave2decode_instr_pc = 100 + i; wave2decode_wfid = 1;
      tick();
    end
    chk("full_at_depth", table_full_err, 0);
    tick();
    chk("full_over_depth", table_full_err, 1);
    clear_inputs();

    salu_retire_valid = 1; lsu_retire_valid = 1; salu_retire_pc = 50; lsu_retire_pc = 51;
    tick();
    chk("ovf_first", overflow_err, 0);
    tick();
    chk("ovf_second", overflow_err, 1); chk("ovf_unit", trace_unit, 0);
    clear_inputs();
    tick(); tick(); tick();
    chk("ovf_sticky", overflow_err, 1);

`ifdef TRACEMON_HALT_CHECK_EN
    rst = 0; tick(); rst = 1;
    wave2decode_instr_valid = 1; wave2decode_wfid = 5; wave2decode_instr_pc = 0;
    tick();
    clear_inputs();
    issue_halt = 1; issue_halt_wfid = 5;
    tick();
    clear_inputs();
    chk("halt_err", halt_err, 1);
`endif

    rst = 0;
    tick();
    rst = 1;
    model_reset();
    compare_all();

    for (int c = 0; c < 400; c++) begin
      random_inputs();
      model_edge();
      tick();
      compare_all();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/trace_monitor.md
Name: trace_monitor

Overview:
Debug trace monitor for the compute unit. It records every instruction issued by the wavepool/decode interface in a small issue table. It captures retirements from SALU, SIMD1-4 and LSU together with their register-file, VCC, EXEC and SCC side effects. Each retirement is matched back to its issued instruction and emitted as one serialized trace record per cycle on a registered output bus.

Parameters:
DEPTH, 16, issue-table entries (power of 2, 2..64)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active low (0 = reset)
wave2decode_instr_valid/_instr/_instr_pc/_sgpr_base/_vgpr_base/_lds_base/_wfid  in  1/32/32/9/10/10/6  issue event
salu2exec_wr_exec_en/_value, salu2exec_wr_vcc_en/_value  in  1/64 each  SALU EXEC/VCC writes
salu_wr_scc_en/_value  in  1/1  SALU SCC write
salu2sgpr_dest_wr_en/_addr/_data  in  1/9/32  SALU SGPR write
simdN2exec_wr_vcc_en/_value (N=1..4)  in  1/64  SIMD VCC write
simdN2vgpr_dest_wr_en/_addr/_data/simdN2vgpr_wr_mask (N=1..4)  in  1/10/2048/64  SIMD VGPR write
lsu2sgpr_dest_wr_en/_addr/_data  in  1/9/32  LSU SGPR write
lsu2vgpr_dest_wr_en/_data  in  1/2048  LSU VGPR write
lsu_dest_str_addr/lsu_dest_str_mask  in  10/64  LSU VGPR dest address/lane mask
lsu_addr/lsu_store_data  in  2048/2048  LSU per-lane address/store data
issue_halt/issue_halt_wfid  in  1/6  wavefront halt
X_retire_valid/X_retire_pc/X_wfid (X=salu,simd1..4,lsu)  in  1/32/6  retirement
trace_valid  out  1  record valid (one cycle)
trace_unit  out  3  0=SALU,1..4=SIMD1..4,5=LSU
trace_wfid/trace_pc/trace_instr  out  6/32/32  retired instruction
trace_sgpr_base/trace_vgpr_base/trace_lds_base  out  9/10/10  bases from issue
trace_miss  out  1  no matching issue entry
trace_dest_en/trace_dest_vgpr/trace_dest_addr/trace_dest_data/trace_dest_mask  out  1/1/10/32/64  register write (data = lane 0)
trace_vcc_en/_value, trace_exec_en/_value, trace_scc_en/_value  out  1/64,1/64,1/1
trace_mem_addr/trace_mem_data  out  32/32  LSU lane-0 address/store data
overflow_err/table_full_err  out  1/1  sticky errors

Behaviour:
- Reset (rst=0 at edge): table invalid, pending slots empty, all outputs 0.
- Issue: instr_valid=1 writes {wfid,pc,instr,bases} into lowest free entry. If the table is full, drop the issue and set table_full_err.
- Retire capture: each unit has a 1-entry pending slot. Its X_retire_valid at edge E loads wfid, pc and side-effect fields, with unused fields zeroed:
  - SALU: dest = SGPR (addr zero-extended, vgpr=0, mask=0); EXEC/VCC/SCC copied.
  - SIMD: dest = VGPR addr, data[31:0], wr_mask; VCC copied.
  - LSU: SGPR write wins if lsu2sgpr_dest_wr_en; else VGPR write (str_addr, data[31:0], str_mask). mem_addr=lsu_addr[31:0], mem_data=lsu_store_data[31:0].
- Retire on an occupied, unserviced slot: sets overflow_err; the new event overwrites the slot.
- Output: each cycle the highest-priority occupied slot (SALU > SIMD1 > ... > SIMD4 > LSU) is registered to trace_* at the next edge, and that slot is cleared. Minimum latency: capture at E, trace_valid after E+1.
- Match: lowest-index valid entry with equal wfid and pc is selected. It supplies instr/bases and is freed at the same edge. No match: trace_miss=1, instr/bases=0.
- Same-cycle issue and free: allocation sees the pre-edge state, so a freed entry is usable the next cycle. An entry written at edge E is matchable from E+1.
- A slot reloaded at the same edge it is serviced takes the new event, with no overflow.
- trace_valid=0 leaves the other outputs holding their last values.
- Errors clear only on reset.

Optional Feature:
TRACEMON_HALT_CHECK_EN:
- Defined: issue_halt=1 with entries still valid for issue_halt_wfid sets sticky output halt_err (1 bit). Those entries are then invalidated.
- Undefined: port halt_err is absent; issue_halt/issue_halt_wfid are ignored.

Test Plan:
- Reset: hold rst=0 for 2 edges -> all outputs 0, table empty.
- Issue pc 0/1/2, instr 10/20/30, sgpr 1, vgpr 2, lds 3, wfid 0; then LSU retire pc 0 with vgpr wr_en, str_addr 6, mask 7, data 15, lsu_addr 0x0000123400005678 -> one record: unit 5, instr 10, dest_vgpr 1, addr 6, data 15, mask 7, mem_addr 0x5678, bases 1/2/3, miss 0.
- SIMD3 (pc 2) and SIMD4 (pc 1) retire the same cycle -> SIMD3 record (instr 30) then SIMD4 record (instr 20, vcc_en 1, vcc 2) on consecutive cycles.
- SALU retire pc 0 with sgpr addr 4, data 23, scc 1 after the entry was already freed -> trace_miss=1, instr 0, dest_data 23, scc_value 1.
- Fill DEPTH+1 issues -> table_full_err=1. Two back-to-back LSU retires while SALU retires both cycles -> overflow_err=1.
- Halt check (macro on): issue wfid 5 then issue_halt wfid 5 -> halt_err=1.
